tl_d_flow_queue: RTL and testbench
==================================

// Module: tl_d_flow_queue
// PURPOSE
//   Parametrised N-entry FIFO for TileLink D-channel beats (opcode/param/size/source/sink/denied/data/corrupt).
//   Successor to the single-entry flow-through D queue: configurable depth, optional flow (empty bypass)
//   and pipe (enq while full if deq fires) modes, plus an occupancy count output.
//   Sits between a D-channel producer (L2/bus) and consumers (LSU/ICache/PTW refill) to decouple timing.
// PARAMETERS
//   DEPTH        2     number of storage entries; legal >= 1, need not be a power of two
//   FLOW         1     1: empty queue passes enq beat to deq combinationally, same cycle
//   PIPE         0     1: io_enq_ready also high when full and io_deq_ready high
//   DATA_W       64    width of io_*_bits_data
//   SOURCE_W     6     width of io_*_bits_source
//   SINK_W       3     width of io_*_bits_sink
// PORTS
//   clock                 in   1              sole clock, rising edge
//   reset                 in   1              synchronous, active-high
//   io_enq_ready          out  1              queue accepts a beat
//   io_enq_valid          in   1              producer offers a beat
//   io_enq_bits_{opcode,param,size,source,sink,denied,data,corrupt}  in  3,2,3,SOURCE_W,SINK_W,1,DATA_W,1
//   io_deq_ready          in   1              consumer accepts a beat
//   io_deq_valid          out  1              beat available
//   io_deq_bits_{opcode,param,size,source,sink,denied,data,corrupt}  out same widths as enq
//   io_count              out  $clog2(DEPTH+1) entries currently held (flow-through beats not counted)
// BEHAVIOUR
//   - State: enq_ptr, deq_ptr ($clog2(DEPTH) bits, min 1), maybe_full. empty = ptr_match & ~maybe_full;
//     full = ptr_match & maybe_full. Pointers wrap DEPTH-1 -> 0 (explicit compare, not power-of-2 rollover).
//   - Reset: pointers 0, maybe_full 0 -> io_count=0, io_enq_ready=1, io_deq_valid=0 (or =io_enq_valid if FLOW).
//     Storage array is not reset; deq bits undefined while io_deq_valid=0.
//   - io_enq_ready = ~full | (PIPE & io_deq_ready). io_deq_valid = ~empty | (FLOW & io_enq_valid).
//   - fire_enq = io_enq_valid & io_enq_ready; fire_deq = io_deq_valid & io_deq_ready.
//   - do_enq = fire_enq, except FLOW & empty & io_deq_ready -> do_enq=0 and do_deq=0 (beat bypasses, no state change).
//   - do_enq: write beat at enq_ptr, enq_ptr++ (wrap). do_deq: deq_ptr++ (wrap).
//   - maybe_full <= do_enq when do_enq != do_deq; unchanged otherwise.
//   - Deq bits: empty & FLOW -> io_enq_bits; else entry[deq_ptr]. Latency: 0 cycles in flow bypass, else 1.
//   - Simultaneous enq+deq when non-empty: count unchanged, both pointers advance; when full only with PIPE.
//   - io_count = maybe_full&ptr_match ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH.
//   - DEPTH=1, FLOW=1, PIPE=0 is cycle-equivalent to the existing single-entry flow-through D queue.
//   - Reset asserted mid-traffic: all beats dropped, outputs return to reset values the next cycle.
//   - io_enq_valid must stay asserted until fire_enq (producer rule); queue holds deq bits stable while
//     io_deq_valid & ~io_deq_ready (not guaranteed for flow-bypass beats, which track io_enq_bits).
// STRUCTURE
//   - Shared package tl_pkg: tl_d_beat_t packed struct (field order corrupt,data,denied,sink,source,size,
//     param,opcode, MSB->LSB), TL_D_OPCODE_W=3, TL_PARAM_W=2, TL_SIZE_W=3, D opcode enum.
//   - One sub-module: tl_queue_ptr (wrapping pointer, parameter DEPTH, inc input) instantiated for enq and deq.
//   - Storage: unpacked array of tl_d_beat_t, DEPTH entries, flop-based.
// TESTING
//   1 Reset, DEPTH=2 FLOW=1: hold reset 2 cycles -> io_count=0, io_enq_ready=1, io_deq_valid=0 with enq_valid=0.
//   2 Flow bypass: empty, enq opcode=1 source=5 data=0xDEAD, deq_ready=1 -> deq same cycle, same bits, count stays 0.
//   3 Fill/drain DEPTH=3: deq_ready=0, enq data 0xA,0xB,0xC -> count 1,2,3, enq_ready=0 at 3; drain -> A,B,C in order.
//   4 Wrap: DEPTH=3, 10 beats streamed with deq_ready toggling 1,0 -> output order matches input, no loss/dup.
//   5 PIPE=1 full, enq_valid=1, deq_ready=1 -> enq_ready=1, count stays DEPTH; PIPE=0 same case -> enq_ready=0.
//   6 Reset mid-operation: count=2, assert reset 1 cycle -> count=0, deq_valid=0, old beats never appear.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink D-channel definitions: field widths, D opcodes and the beat layout.
package tl_pkg;

    localparam int TL_D_OPCODE_W = 3;
    localparam int TL_PARAM_W    = 2;
    localparam int TL_SIZE_W     = 3;
    localparam int TL_DATA_W     = 64;
    localparam int TL_SOURCE_W   = 6;
    localparam int TL_SINK_W     = 3;

    typedef enum logic [TL_D_OPCODE_W-1:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } tl_d_opcode_e;

    // Default-width beat; queues with other widths declare a local struct in the same field order.
    typedef struct packed {
        logic                     corrupt;
        logic [TL_DATA_W-1:0]     data;
        logic                     denied;
        logic [TL_SINK_W-1:0]     sink;
        logic [TL_SOURCE_W-1:0]   source;
        logic [TL_SIZE_W-1:0]     size;
        logic [TL_PARAM_W-1:0]    param;
        logic [TL_D_OPCODE_W-1:0] opcode;
    } tl_d_beat_t;

    // Pointer width for a DEPTH-entry ring; a single entry still gets one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tl_queue_ptr.sv
// Wrapping ring pointer: advances on inc, rolls DEPTH-1 -> 0 for any DEPTH.
module tl_queue_ptr
    import tl_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/tl_d_flow_queue.sv
// N-entry TileLink D-channel FIFO with optional empty bypass (FLOW) and full pass-through (PIPE).
module tl_d_flow_queue
    import tl_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int FLOW     = 1,
    parameter int PIPE     = 0,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int SINK_W   = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_enq_ready,
    input  logic                     io_enq_valid,
    input  logic [TL_D_OPCODE_W-1:0] io_enq_bits_opcode,
    input  logic [TL_PARAM_W-1:0]    io_enq_bits_param,
    input  logic [TL_SIZE_W-1:0]     io_enq_bits_size,
    input  logic [SOURCE_W-1:0]      io_enq_bits_source,
    input  logic [SINK_W-1:0]        io_enq_bits_sink,
    input  logic                     io_enq_bits_denied,
    input  logic [DATA_W-1:0]        io_enq_bits_data,
    input  logic                     io_enq_bits_corrupt,
    input  logic                     io_deq_ready,
    output logic                     io_deq_valid,
    output logic [TL_D_OPCODE_W-1:0] io_deq_bits_opcode,
    output logic [TL_PARAM_W-1:0]    io_deq_bits_param,
    output logic [TL_SIZE_W-1:0]     io_deq_bits_size,
    output logic [SOURCE_W-1:0]      io_deq_bits_source,
    output logic [SINK_W-1:0]        io_deq_bits_sink,
    output logic                     io_deq_bits_denied,
    output logic [DATA_W-1:0]        io_deq_bits_data,
    output logic                     io_deq_bits_corrupt,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam bit FLOW_B = (FLOW != 0);
    localparam bit PIPE_B = (PIPE != 0);

    typedef struct packed {
        logic                     corrupt;
        logic [DATA_W-1:0]        data;
        logic                     denied;
        logic [SINK_W-1:0]        sink;
        logic [SOURCE_W-1:0]      source;
        logic [TL_SIZE_W-1:0]     size;
        logic [TL_PARAM_W-1:0]    param;
        logic [TL_D_OPCODE_W-1:0] opcode;
    } beat_t;

    beat_t            mem [DEPTH];
    beat_t            enq_beat, deq_beat;
    logic [PTR_W-1:0] enq_ptr, deq_ptr;
    logic             maybe_full, ptr_match, empty, full;
    logic             fire_enq, fire_deq, bypass, do_enq, do_deq;
    int               cnt;

    assign enq_beat = '{corrupt: io_enq_bits_corrupt, data: io_enq_bits_data,
                        denied:  io_enq_bits_denied,  sink: io_enq_bits_sink,
                        source:  io_enq_bits_source,  size: io_enq_bits_size,
                        param:   io_enq_bits_param,   opcode: io_enq_bits_opcode};

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match &  maybe_full;

    assign io_enq_ready = ~full | (PIPE_B & io_deq_ready);
    assign io_deq_valid = ~empty | (FLOW_B & io_enq_valid);

    assign fire_enq = io_enq_valid & io_enq_ready;
    assign fire_deq = io_deq_valid & io_deq_ready;
    // A beat that flows straight through an empty queue never touches storage.
    assign bypass   = FLOW_B & empty & io_deq_ready;
    assign do_enq   = fire_enq & ~bypass;
    assign do_deq   = fire_deq & ~bypass;

    tl_queue_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (do_enq),
        .ptr   (enq_ptr)
    );

    tl_queue_ptr #(.DEPTH(DEPTH)) u_deq_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (do_deq),
        .ptr   (deq_ptr)
    );

    always_ff @(posedge clock) begin
        if (reset)
            maybe_full <= 1'b0;
        else if (do_enq != do_deq)
            maybe_full <= do_enq;
    end

    // Storage is deliberately left unreset; contents are only observed behind valid.
    always_ff @(posedge clock) begin
        if (do_enq)
            mem[enq_ptr] <= enq_beat;
    end

    assign deq_beat = (FLOW_B && empty) ? enq_beat : mem[deq_ptr];

    assign io_deq_bits_opcode  = deq_beat.opcode;
    assign io_deq_bits_param   = deq_beat.param;
    assign io_deq_bits_size    = deq_beat.size;
    assign io_deq_bits_source  = deq_beat.source;
    assign io_deq_bits_sink    = deq_beat.sink;
    assign io_deq_bits_denied  = deq_beat.denied;
    assign io_deq_bits_data    = deq_beat.data;
    assign io_deq_bits_corrupt = deq_beat.corrupt;

    // Occupancy modulo DEPTH; full is the one case the pointer difference cannot express.
    always_comb begin
        cnt = 0;
        if (full)
            cnt = DEPTH;
        else if (enq_ptr >= deq_ptr)
            cnt = int'(enq_ptr) - int'(deq_ptr);
        else
            cnt = DEPTH + int'(enq_ptr) - int'(deq_ptr);
    end

    assign io_count = CNT_W'(cnt);

endmodule

// File: tb/tb_tl_d_flow_queue.sv
// Randomised check of two queue configurations against a queue-of-beats reference model.
module tb_tl_d_flow_queue;

    localparam int DA = 3;   // FLOW=1 PIPE=0
    localparam int DB = 2;   // FLOW=0 PIPE=1

    typedef struct packed {
        logic        corrupt;
        logic [63:0] data;
        logic        denied;
        logic [2:0]  sink;
        logic [5:0]  source;
        logic [2:0]  size;
        logic [1:0]  param;
        logic [2:0]  opcode;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic a_ev = 1'b0, a_dr = 1'b0, b_ev = 1'b0, b_dr = 1'b0;
    beat_t a_eb = '0, b_eb = '0;
    logic a_er, a_dv, b_er, b_dv;
    logic [1:0] a_cnt, b_cnt;
    beat_t a_db, b_db;

    logic [2:0]  ao_opcode, bo_opcode, ao_size, bo_size, ao_sink, bo_sink;
    logic [1:0]  ao_param, bo_param;
    logic [5:0]  ao_source, bo_source;
    logic        ao_denied, bo_denied, ao_corrupt, bo_corrupt;
    logic [63:0] ao_data, bo_data;

    assign a_db = '{corrupt: ao_corrupt, data: ao_data, denied: ao_denied, sink: ao_sink,
                    source: ao_source, size: ao_size, param: ao_param, opcode: ao_opcode};
    assign b_db = '{corrupt: bo_corrupt, data: bo_data, denied: bo_denied, sink: bo_sink,
                    source: bo_source, size: bo_size, param: bo_param, opcode: bo_opcode};

    tl_d_flow_queue #(.DEPTH(DA), .FLOW(1), .PIPE(0)) dut_a (
        .clock(clock), .reset(reset),
        .io_enq_ready(a_er), .io_enq_valid(a_ev),
        .io_enq_bits_opcode(a_eb.opcode), .io_enq_bits_param(a_eb.param),
        .io_enq_bits_size(a_eb.size), .io_enq_bits_source(a_eb.source),
        .io_enq_bits_sink(a_eb.sink), .io_enq_bits_denied(a_eb.denied),
        .io_enq_bits_data(a_eb.data), .io_enq_bits_corrupt(a_eb.corrupt),
        .io_deq_ready(a_dr), .io_deq_valid(a_dv),
        .io_deq_bits_opcode(ao_opcode), .io_deq_bits_param(ao_param),
        .io_deq_bits_size(ao_size), .io_deq_bits_source(ao_source),
        .io_deq_bits_sink(ao_sink), .io_deq_bits_denied(ao_denied),
        .io_deq_bits_data(ao_data), .io_deq_bits_corrupt(ao_corrupt),
        .io_count(a_cnt)
    );

    tl_d_flow_queue #(.DEPTH(DB), .FLOW(0), .PIPE(1)) dut_b (
        .clock(clock), .reset(reset),
        .io_enq_ready(b_er), .io_enq_valid(b_ev),
        .io_enq_bits_opcode(b_eb.opcode), .io_enq_bits_param(b_eb.param),
        .io_enq_bits_size(b_eb.size), .io_enq_bits_source(b_eb.source),
        .io_enq_bits_sink(b_eb.sink), .io_enq_bits_denied(b_eb.denied),
        .io_enq_bits_data(b_eb.data), .io_enq_bits_corrupt(b_eb.corrupt),
        .io_deq_ready(b_dr), .io_deq_valid(b_dv),
        .io_deq_bits_opcode(bo_opcode), .io_deq_bits_param(bo_param),
        .io_deq_bits_size(bo_size), .io_deq_bits_source(bo_source),
        .io_deq_bits_sink(bo_sink), .io_deq_bits_denied(bo_denied),
        .io_deq_bits_data(bo_data), .io_deq_bits_corrupt(bo_corrupt),
        .io_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    beat_t qa[$];
    beat_t qb[$];
    logic a_fired = 1'b0, b_fired = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of beats plus the ready/valid rules, nothing about pointers.
    function automatic void mdl(input int depth, input bit flow, input bit pipe, input int size,
                                input beat_t front, input logic ev, input beat_t eb, input logic dr,
                                output logic er, output logic dv, output beat_t db, output logic byp);
        er  = (size < depth) || (pipe && dr);
        dv  = (size > 0) || (flow && ev);
        db  = (size == 0) ? eb : front;
        byp = flow && (size == 0) && ev && dr;
    endfunction

    task automatic tick();
        logic er, dv, byp;
        beat_t db, front;
        logic a_fe = 1'b0, a_fd = 1'b0, a_byp = 1'b0;
        logic b_fe = 1'b0, b_fd = 1'b0, b_byp = 1'b0;
        @(negedge clock);
        if (!reset) begin
            front = (qa.size() > 0) ? qa[0] : beat_t'(0);
            mdl(DA, 1'b1, 1'b0, qa.size(), front, a_ev, a_eb, a_dr, er, dv, db, byp);
            chk("a_enq_ready", 128'(a_er), 128'(er));
            chk("a_deq_valid", 128'(a_dv), 128'(dv));
            chk("a_count", 128'(a_cnt), 128'(qa.size()));
            if (dv) chk("a_deq_bits", 128'(a_db), 128'(db));
            a_fe = a_ev && er; a_fd = dv && a_dr; a_byp = byp;

            front = (qb.size() > 0) ? qb[0] : beat_t'(0);
            mdl(DB, 1'b0, 1'b1, qb.size(), front, b_ev, b_eb, b_dr, er, dv, db, byp);
            chk("b_enq_ready", 128'(b_er), 128'(er));
            chk("b_deq_valid", 128'(b_dv), 128'(dv));
            chk("b_count", 128'(b_cnt), 128'(qb.size()));
            if (dv) chk("b_deq_bits", 128'(b_db), 128'(db));
            b_fe = b_ev && er; b_fd = dv && b_dr; b_byp = byp;
        end
        @(posedge clock);
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (!a_byp) begin
                if (a_fd) void'(qa.pop_front());
                if (a_fe) qa.push_back(a_eb);
            end
            if (!b_byp) begin
                if (b_fd) void'(qb.pop_front());
                if (b_fe) qb.push_back(b_eb);
            end
        end
        a_fired = a_fe;
        b_fired = b_fe;
        #1;
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic [2:0] op, input logic [5:0] src);
        beat_t b;
        b = '0;
        b.data = d; b.opcode = op; b.source = src;
        return b;
    endfunction

    function automatic beat_t rnd();
        beat_t b;
        b.corrupt = 1'($urandom); b.data = {$urandom, $urandom}; b.denied = 1'($urandom);
        b.sink = 3'($urandom); b.source = 6'($urandom); b.size = 3'($urandom);
        b.param = 2'($urandom); b.opcode = 3'($urandom);
        return b;
    endfunction

    task automatic drv(input logic ev, input beat_t eb, input logic dr);
        a_ev = ev; a_eb = eb; a_dr = dr;
        b_ev = ev; b_eb = eb; b_dr = dr;
    endtask

    initial begin
        drv(1'b0, '0, 1'b0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();                                         // idle after reset

        drv(1'b1, mk(64'hDEAD, 3'd1, 6'd5), 1'b1);      // flow bypass on A
        tick();
        drv(1'b0, '0, 1'b1);
        tick(); tick();

        for (int k = 0; k < 3; k++) begin               // fill
            drv(1'b1, mk(64'hA + 64'(k), 3'd1, 6'(k)), 1'b0);
            tick();
        end
        drv(1'b0, '0, 1'b0);
        tick();                                         // A full, enq_ready low
        drv(1'b1, mk(64'h55, 3'd0, 6'd9), 1'b1);        // full + deq_ready: only PIPE accepts
        tick();
        chk("pipe0_not_ready_while_full", 128'(qa.size()), 128'(DA - 1));
        chk("pipe1_count_stays_full", 128'(qb.size()), 128'(DB));
        drv(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) tick();             // drain

        for (int i = 0; i < 10; i++) begin              // wrap with toggling deq_ready
            drv(1'b1, mk(64'h100 + 64'(i), 3'd1, 6'(i)), (i % 2) == 0);
            tick();
        end
        drv(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) tick();

        for (int k = 0; k < 2; k++) begin               // two beats parked, then reset
            drv(1'b1, mk(64'hBAD0 + 64'(k), 3'd2, 6'd1), 1'b0);
            tick();
        end
        drv(1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_drops_a", 128'(a_cnt), 128'(0));
        drv(1'b1, mk(64'h77, 3'd1, 6'd3), 1'b1);
        tick();
        drv(1'b0, '0, 1'b1);
        tick(); tick();

        for (int c = 0; c < 3000; c++) begin
            if (!(a_ev && !a_fired)) begin a_ev = ($urandom_range(0, 3) != 0); a_eb = rnd(); end
            if (!(b_ev && !b_fired)) begin b_ev = ($urandom_range(0, 3) != 0); b_eb = rnd(); end
            a_dr = ($urandom_range(0, 2) != 0);
            b_dr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                drv(1'b0, '0, 1'b0);
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
